// File: rtl/decode_pipe_pkg.sv
// decode_pipe_pkg: RV32 opcode/funct7 constants, decode bundle types and immediate helper
package decode_pipe_pkg;
  localparam logic [4:0] OP_LOAD     = 5'b00000;
  localparam logic [4:0] OP_MISC_MEM = 5'b00011;
  localparam logic [4:0] OP_IMM      = 5'b00100;
  localparam logic [4:0] OP_AUIPC    = 5'b00101;
  localparam logic [4:0] OP_STORE    = 5'b01000;
  localparam logic [4:0] OP_OP       = 5'b01100;
  localparam logic [4:0] OP_LUI      = 5'b01101;
  localparam logic [4:0] OP_BRANCH   = 5'b11000;
  localparam logic [4:0] OP_JALR     = 5'b11001;
  localparam logic [4:0] OP_JAL      = 5'b11011;
  localparam logic [4:0] OP_SYSTEM   = 5'b11100;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
  typedef struct packed {
    logic rd_en;
    logic rs1_en;
    logic rs2_en;
    logic imm_en;
    logic pc_sel;
    logic alu_en;
    logic alu_flag;
    logic is_muldiv;
    logic mem_en;
    logic mem_we;
    logic is_jmp;
    logic is_branch;
    logic is_fence;
    logic is_system;
    logic is_invalid;
  } ctrl_t;
  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
  } fields_t;
  localparam ctrl_t CTRL_INV = '{is_invalid: 1'b1, default: 1'b0};
  function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_fmt_e f);
    case (f)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/decode_pipe_if.sv
// decode_pipe_if: fetch-side and execute-side handshakes plus the decoded bundle
interface decode_pipe_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] imm;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      funct3;
  logic rd_en, rs1_en, rs2_en, imm_en, pc_sel, alu_en, alu_flag, is_muldiv;
  logic mem_en, mem_we, is_jmp, is_branch, is_fence, is_system, is_invalid;
  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, imm, rd, rs1, rs2, funct3,
    input  rd_en, rs1_en, rs2_en, imm_en, pc_sel, alu_en, alu_flag, is_muldiv,
    input  mem_en, mem_we, is_jmp, is_branch, is_fence, is_system, is_invalid
  );
  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, imm, rd, rs1, rs2, funct3,
    output rd_en, rs1_en, rs2_en, imm_en, pc_sel, alu_en, alu_flag, is_muldiv,
    output mem_en, mem_we, is_jmp, is_branch, is_fence, is_system, is_invalid
  );
endinterface

// File: rtl/decode_pipe_rv_decode_comb.sv
// rv_decode_comb: combinational RV32I(+M) instruction word to control bundle, fields and immediate
module rv_decode_comb
  import decode_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b1
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output ctrl_t           ctrl,
  output fields_t         fields,
  output logic [XLEN-1:0] pc_f,
  output logic [XLEN-1:0] imm
);
  logic [4:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  ctrl_t      c;
  imm_fmt_e   fmt;
  logic       ok;
  logic       invalid;
  assign op = inst[6:2];
  assign f3 = inst[14:12];
  assign f7 = inst[31:25];
  always_comb begin
    c = '0;
    fmt = IMM_NONE;
    ok = 1'b1;
    case (op)
      OP_LUI:      begin c.rd_en = 1'b1; c.imm_en = 1'b1; c.alu_en = 1'b1; fmt = IMM_U; end
      OP_AUIPC:    begin c.rd_en = 1'b1; c.imm_en = 1'b1; c.alu_en = 1'b1; c.pc_sel = 1'b1; fmt = IMM_U; end
      OP_JAL:      begin c.rd_en = 1'b1; c.is_jmp = 1'b1; fmt = IMM_J; end
      OP_JALR:     begin c.rd_en = 1'b1; c.rs1_en = 1'b1; c.is_jmp = 1'b1; fmt = IMM_I; ok = f3 == 3'b000; end
      OP_BRANCH:   begin
        c.is_branch = 1'b1; c.alu_en = 1'b1; c.rs1_en = 1'b1; c.rs2_en = 1'b1; fmt = IMM_B;
        ok = f3 != 3'b010 && f3 != 3'b011;
      end
      OP_LOAD:     begin
        c.mem_en = 1'b1; c.rs1_en = 1'b1; c.rd_en = 1'b1; fmt = IMM_I;
        ok = f3 != 3'b011 && f3[2:1] != 2'b11;
      end
      OP_STORE:    begin
        c.mem_en = 1'b1; c.mem_we = 1'b1; c.rs1_en = 1'b1; c.rs2_en = 1'b1; fmt = IMM_S;
        ok = f3 < 3'b011;
      end
      OP_IMM:      begin
        c.alu_en = 1'b1; c.rd_en = 1'b1; c.rs1_en = 1'b1; c.imm_en = 1'b1; fmt = IMM_I;
        c.alu_flag = f3 == 3'b101 && inst[30];
        ok = f3 == 3'b001 ? f7 == F7_BASE : f3 == 3'b101 ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1;
      end
      OP_OP:       begin
        c.alu_en = 1'b1; c.rd_en = 1'b1; c.rs1_en = 1'b1; c.rs2_en = 1'b1;
        c.alu_flag = inst[30];
        c.is_muldiv = f7 == F7_MULDIV;
        ok = f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) || (EN_M && f7 == F7_MULDIV);
      end
      OP_MISC_MEM: begin c.is_fence = 1'b1; fmt = IMM_I; end
      OP_SYSTEM:   begin c.is_system = 1'b1; fmt = IMM_I; end
      default:     ok = 1'b0;
    endcase
  end
  assign invalid = !ok || inst[1:0] != 2'b11;
  assign ctrl = invalid ? CTRL_INV : c;
  assign fields = invalid ? '0 : '{rd: inst[11:7], rs1: op == OP_LUI ? 5'd0 : inst[19:15], rs2: inst[24:20], funct3: f3};
  assign pc_f = invalid ? '0 : pc;
  assign imm = invalid ? '0 : XLEN'($signed(imm_gen(inst, fmt)));
endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: in-order instruction queue with bypass feeding a registered RV32 decode bundle
module decode_pipe
  import decode_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter bit EN_M  = 1'b1
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       flush,
  decode_pipe_if.slave               bus,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [31:0]     q_inst [DEPTH];
  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [PW-1:0]   wp, rp;
  logic            push, load, pop, enq, has_q;
  logic [31:0]     src_inst;
  logic [XLEN-1:0] src_pc, d_pc, d_imm, pc_q, imm_q;
  ctrl_t           d_ctrl, ctrl_q;
  fields_t         d_fld, fld_q;
  logic            valid_q;
  assign has_q = count != '0;
  assign bus.in_ready = count < CW'(DEPTH) && !flush;
  assign push = bus.in_valid && bus.in_ready;
  assign load = !valid_q || bus.out_ready;
  assign pop = load && has_q;
  // a queued entry always wins the output register, so a new beat can only bypass an empty queue
  assign enq = push && !(load && !has_q);
  assign src_inst = has_q ? q_inst[rp] : bus.in_inst;
  assign src_pc = has_q ? q_pc[rp] : bus.in_pc;
  rv_decode_comb #(.XLEN(XLEN), .EN_M(EN_M)) u_dec (
    .inst(src_inst), .pc(src_pc), .ctrl(d_ctrl), .fields(d_fld), .pc_f(d_pc), .imm(d_imm)
  );
  always_ff @(posedge clk) begin
    if (enq) begin
      q_inst[wp] <= bus.in_inst;
      q_pc[wp] <= bus.in_pc;
    end
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count <= '0;
      wp <= '0;
      rp <= '0;
      valid_q <= 1'b0;
      ctrl_q <= '0;
      fld_q <= '0;
      pc_q <= '0;
      imm_q <= '0;
    end else if (flush) begin
      count <= '0;
      wp <= '0;
      rp <= '0;
      valid_q <= 1'b0;
      ctrl_q <= '0;
      fld_q <= '0;
      pc_q <= '0;
      imm_q <= '0;
    end else begin
      if (enq) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
      count <= count + CW'(enq) - CW'(pop);
      if (load) begin
        valid_q <= has_q || push;
        ctrl_q <= d_ctrl;
        fld_q <= d_fld;
        pc_q <= d_pc;
        imm_q <= d_imm;
      end
    end
  end
  assign bus.out_valid = valid_q;
  assign bus.out_pc = pc_q;
  assign bus.imm = imm_q;
  assign {bus.rd, bus.rs1, bus.rs2, bus.funct3} = fld_q;
  assign {bus.rd_en, bus.rs1_en, bus.rs2_en, bus.imm_en, bus.pc_sel, bus.alu_en, bus.alu_flag,
          bus.is_muldiv, bus.mem_en, bus.mem_we, bus.is_jmp, bus.is_branch, bus.is_fence,
          bus.is_system, bus.is_invalid} = ctrl_q;
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed scoreboard bench for decode_pipe with EN_M=1 and EN_M=0 instances
module tb_decode_pipe;
  localparam int DEPTH = 2;
  localparam logic [14:0] RD = 15'h4000, RS1 = 15'h2000, RS2 = 15'h1000, IMM = 15'h0800;
  localparam logic [14:0] ALU = 15'h0200, FLG = 15'h0100, MD = 15'h0080;
  localparam logic [14:0] MEM = 15'h0040, WE = 15'h0020, BR = 15'h0008, INV = 15'h0001;
  typedef logic [96:0] vec_t;
  typedef struct {
    vec_t m1;
    vec_t m0;
  } exp_t;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic flush = 1'b0;
  logic [1:0] count, count0;
  exp_t sb[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  decode_pipe_if #(.XLEN(32)) b ();
  decode_pipe_if #(.XLEN(32)) b0 ();
  decode_pipe #(.XLEN(32), .DEPTH(DEPTH), .EN_M(1'b1)) dut (
    .clk(clk), .nreset(nreset), .flush(flush), .bus(b), .count(count)
  );
  decode_pipe #(.XLEN(32), .DEPTH(DEPTH), .EN_M(1'b0)) dut0 (
    .clk(clk), .nreset(nreset), .flush(flush), .bus(b0), .count(count0)
  );
  assign b0.in_valid = b.in_valid;
  assign b0.in_inst = b.in_inst;
  assign b0.in_pc = b.in_pc;
  assign b0.out_ready = b.out_ready;
  vec_t obs1, obs0;
  assign obs1 = {b.out_pc, b.rd, b.rs1, b.rs2, b.funct3, b.imm,
                 b.rd_en, b.rs1_en, b.rs2_en, b.imm_en, b.pc_sel, b.alu_en, b.alu_flag, b.is_muldiv,
                 b.mem_en, b.mem_we, b.is_jmp, b.is_branch, b.is_fence, b.is_system, b.is_invalid};
  assign obs0 = {b0.out_pc, b0.rd, b0.rs1, b0.rs2, b0.funct3, b0.imm,
                 b0.rd_en, b0.rs1_en, b0.rs2_en, b0.imm_en, b0.pc_sel, b0.alu_en, b0.alu_flag, b0.is_muldiv,
                 b0.mem_en, b0.mem_we, b0.is_jmp, b0.is_branch, b0.is_fence, b0.is_system, b0.is_invalid};
  function automatic vec_t pk(input logic [31:0] pc, input logic [4:0] rd, rs1, rs2,
                              input logic [2:0] f3, input logic [31:0] imm, input logic [14:0] c);
    return {pc, rd, rs1, rs2, f3, imm, c};
  endfunction
  function automatic logic [31:0] addi(input int k);
    return {12'(k), 5'd0, 3'd0, 5'(k), 7'h13};
  endfunction
  function automatic vec_t addi_e(input int k, input logic [31:0] pc);
    return pk(pc, 5'(k), 5'd0, 5'(k), 3'd0, 32'(k), RD | RS1 | IMM | ALU);
  endfunction
  task automatic chk(input string tag, input vec_t obs, input vec_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input vec_t m1, input vec_t m0, input bit track);
    int n;
    n = 0;
    b.in_valid = 1'b1;
    b.in_inst = inst;
    b.in_pc = pc;
    @(negedge clk);
    while (!b.in_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!b.in_ready) chk("send_timeout", vec_t'(b.in_ready), vec_t'(1));
    else if (track) sb.push_back('{m1, m0});
    tick();
    b.in_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    if (nreset && !flush && b.out_valid && b.out_ready) begin
      if (sb.size() == 0) chk("spurious_out", vec_t'(b.out_valid), vec_t'(0));
      else begin
        mon_e = sb.pop_front();
        chk("out_enm1", obs1, mon_e.m1);
        chk("out_enm0", obs0, mon_e.m0);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1);
  end
  initial begin
    vec_t inv_e;
    inv_e = pk(32'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, INV);
    b.in_valid = 1'b0;
    b.in_inst = '0;
    b.in_pc = '0;
    b.out_ready = 1'b1;
    #1;
    chk("rst_outputs", obs1, vec_t'(0));
    chk("rst_valid_count", vec_t'({b.out_valid, count}), vec_t'(0));
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    tick();
    chk("idle_in_ready", vec_t'(b.in_ready), vec_t'(1));
    send(32'h00500093, 32'h100, pk(32'h100, 5'd1, 5'd0, 5'd5, 3'd0, 32'd5, RD | RS1 | IMM | ALU),
         pk(32'h100, 5'd1, 5'd0, 5'd5, 3'd0, 32'd5, RD | RS1 | IMM | ALU), 1'b1);
    chk("bypass_latency", vec_t'({b.out_valid, count}), vec_t'(3'b100));
    send(32'h123452B7, 32'h104, pk(32'h104, 5'd5, 5'd0, 5'd3, 3'd5, 32'h12345000, RD | IMM | ALU),
         pk(32'h104, 5'd5, 5'd0, 5'd3, 3'd5, 32'h12345000, RD | IMM | ALU), 1'b1);
    send(32'h0020A423, 32'h108, pk(32'h108, 5'd8, 5'd1, 5'd2, 3'd2, 32'd8, RS1 | RS2 | MEM | WE),
         pk(32'h108, 5'd8, 5'd1, 5'd2, 3'd2, 32'd8, RS1 | RS2 | MEM | WE), 1'b1);
    send(32'h022081B3, 32'h10C, pk(32'h10C, 5'd3, 5'd1, 5'd2, 3'd0, 32'd0, RD | RS1 | RS2 | ALU | MD),
         inv_e, 1'b1);
    send(32'h40325213, 32'h110, pk(32'h110, 5'd4, 5'd4, 5'd3, 3'd5, 32'h403, RD | RS1 | IMM | ALU | FLG),
         pk(32'h110, 5'd4, 5'd4, 5'd3, 3'd5, 32'h403, RD | RS1 | IMM | ALU | FLG), 1'b1);
    send(32'h00007067, 32'h114, inv_e, inv_e, 1'b1);
    send(32'hFE000EE3, 32'h118, pk(32'h118, 5'd29, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFC, RS1 | RS2 | ALU | BR),
         pk(32'h118, 5'd29, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFC, RS1 | RS2 | ALU | BR), 1'b1);
    send(32'h00500091, 32'h11C, inv_e, inv_e, 1'b1);
    tick();
    chk("drain_directed", vec_t'({sb.size() == 0, b.out_valid}), vec_t'(2'b10));
    b.out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) send(addi(k), 32'h200 + 4 * k, addi_e(k, 32'h200 + 4 * k), addi_e(k, 32'h200 + 4 * k), 1'b1);
    chk("full_state", vec_t'({count, b.in_ready, b.out_valid}), vec_t'(4'b1001));
    b.in_valid = 1'b1;
    b.in_inst = addi(4);
    b.in_pc = 32'h210;
    repeat (2) begin
      @(negedge clk);
      chk("full_blocks_in", vec_t'({count, b.in_ready}), vec_t'(3'b100));
      chk("hold_stable", obs1, addi_e(1, 32'h204));
    end
    tick();
    b.out_ready = 1'b1;
    send(addi(4), 32'h210, addi_e(4, 32'h210), addi_e(4, 32'h210), 1'b1);
    tick();
    tick();
    chk("stream_one_per_cycle", vec_t'({sb.size() == 0, b.out_valid, count}), vec_t'(4'b1000));
    b.out_ready = 1'b0;
    for (int k = 5; k <= 7; k++) send(addi(k), 32'h300 + 4 * k, '0, '0, 1'b0);
    chk("prefl_state", vec_t'({count, b.out_valid}), vec_t'(3'b101));
    b.in_valid = 1'b1;
    b.in_inst = addi(8);
    b.in_pc = 32'h320;
    b.out_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", vec_t'(b.in_ready), vec_t'(0));
    tick();
    flush = 1'b0;
    b.in_valid = 1'b0;
    chk("flush_clears", vec_t'({count, b.out_valid, count0, b0.out_valid}), vec_t'(0));
    chk("flush_outputs", obs1, vec_t'(0));
    tick();
    chk("flush_drops_beat", vec_t'({count, b.out_valid}), vec_t'(0));
    b.out_ready = 1'b0;
    for (int k = 9; k <= 10; k++) send(addi(k), 32'h400 + 4 * k, '0, '0, 1'b0);
    chk("prerst_state", vec_t'({count, b.out_valid}), vec_t'(3'b011));
    #2 nreset = 1'b0;
    #1;
    chk("rst_mid_outputs", obs1, vec_t'(0));
    chk("rst_mid_state", vec_t'({count, b.out_valid, count0, b0.out_valid}), vec_t'(0));
    tick();
    nreset = 1'b1;
    sb.delete();
    b.out_ready = 1'b1;
    send(addi(11), 32'h500, addi_e(11, 32'h500), addi_e(11, 32'h500), 1'b1);
    chk("post_rst_bypass", vec_t'({b.out_valid, count}), vec_t'(3'b100));
    tick();
    chk("final_drain", vec_t'({sb.size() == 0, b.out_valid}), vec_t'(2'b10));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode_pipe.md
# decode_pipe

Registered, back-pressured RV32 instruction decode stage placed between fetch and the register-read/execute logic. It buffers fetched instructions in a small in-order queue and decodes them into a registered control bundle. It also generates the sign-extended immediate and validates funct3/funct7 (optional M-extension) per instruction, and offers valid/ready handshakes on both sides plus a synchronous pipeline flush.

## Interface
- XLEN, 32: datapath width of pc/imm (32 or 64); imm sign-extended to XLEN.
- DEPTH, 2: instruction queue entries (power of 2, ≥1).
- EN_M, 1: 1 = OP with funct7=0000001 decodes as mul/div; 0 = invalid.
- clk  in  1  clock, all state on rising edge.
- nreset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards queue and output register.
- in_valid / in_ready  in / out  1  fetch handshake; transfer when both high.
- in_inst / in_pc  in  32 / XLEN  instruction word and its address.
- out_valid / out_ready  out / in  1  execute handshake.
- out_pc  out  XLEN;  rd, rs1, rs2  out  5;  funct3  out  3;  imm  out  XLEN.
- rd_en, rs1_en, rs2_en, imm_en, pc_sel, alu_en, alu_flag, is_muldiv, mem_en, mem_we, is_jmp, is_branch, is_fence, is_system, is_invalid  out  1 each.
- count  out  $clog2(DEPTH+1)  queue occupancy, excluding output register.

## Operation
- Queue: FIFO of {inst, pc}, DEPTH entries, order preserved. in_ready = (count < DEPTH) && !flush.
- Output register loads when empty or drained this cycle (out_valid && out_ready); source = queue head if count>0, else incoming beat (bypass). Incoming beat never overtakes a queued entry.
- Decode classes by inst[6:2]: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM.
- LUI: rs1 forced 0, rs1_en=0, imm_en=1. AUIPC: pc_sel=1, imm_en=1. Both alu_en=1, rd_en=1.
- JAL/JALR: is_jmp=1, rd_en=1; JALR rs1_en=1. BRANCH: is_branch=1, alu_en=1, rs1_en=rs2_en=1, rd_en=0.
- LOAD: mem_en=1, rs1_en=1, rd_en=1, mem_we=0. STORE: mem_en=1, mem_we=1, rs1_en=rs2_en=1.
- OP-IMM: alu_en, rd_en, rs1_en, imm_en. OP: alu_en, rd_en, rs1_en, rs2_en; is_muldiv=1 when funct7=0000001.
- alu_flag = inst[30] only for OP (funct7 0100000) and OP-IMM funct3=101; else 0.
- Immediate: I, S, B (bit0=0), U (low 12 zero), J (bit0=0) formats, sign-extended from inst[31].
- is_invalid=1 and every other enable 0 when: inst[1:0]≠11; unknown opcode; JALR funct3≠000; BRANCH funct3 010/011; LOAD funct3 011/110/111; STORE funct3 ≥011; OP funct7 not {0000000, 0100000 with funct3 000/101, 0000001 if EN_M}; OP-IMM funct3 001 with funct7≠0, or funct3 101 with funct7 not 0000000/0100000.
- Field outputs (rd, rs1, rs2, funct3, out_pc) pass raw except LUI rs1 and invalid (all zero).

## Timing
- Reset (nreset low, asynchronous): count=0, queue pointers 0, out_valid=0, every decoded output 0.
- Latency: bypass path 1 cycle (beat at edge N → out_valid after edge N); via queue ≥2 cycles.
- Outputs stable while out_valid && !out_ready.
- Full: count=DEPTH and output held → in_ready=0; simultaneous drain and push with count=DEPTH not allowed (in_ready is registered-count based).
- Simultaneous push/pop at count>0: count unchanged, pointers wrap modulo DEPTH.
- flush: next edge count=0, out_valid=0; beat presented during flush is dropped (in_ready=0); flush beats out_ready.
- Reset mid-transfer: all state cleared, no partial output.

## Structure
- Shared package: opcode constants (5-bit inst[6:2]), funct7 constants, immediate-format enum.
- One sub-module: rv_decode_comb (pure combinational inst → control bundle + imm, parameter XLEN, EN_M); decode_pipe adds queue, bypass and output register.

## Test plan
- 0x00500093 (ADDI x1,x0,5), idle pipe → next cycle out_valid, rd=1, rs1=0, imm=5, alu_en=rd_en=imm_en=1.
- 0x123452B7 (LUI x5) → rd=5, rs1=0, imm=0x12345000, rs1_en=0; 0x0020A423 (SW x2,8(x1)) → mem_we=1, imm=8, rd_en=0.
- 0x022081B3 (MUL x3,x1,x2): EN_M=1 → is_muldiv=1; EN_M=0 → is_invalid=1, all enables 0.
- 0x40325213 (SRAI x4,x4,3) → alu_flag=1; 0x00007067 (JALR funct3=111) → is_invalid=1.
- out_ready=0, push DEPTH+1 beats → in_ready low with count=DEPTH; release → beats emerge in order, one per cycle.
- flush with queue full and out_valid=1 → next cycle count=0, out_valid=0; nreset asserted mid-stream → all outputs 0 immediately.
